// File: rtl/uart_tx_buf_pkg.sv
// Shared UART definitions: frame-state encoding, parity mode constants and a
// constant-evaluable ceil(log2) used to size counters and FIFO pointers.
package uart_tx_buf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// Synchronous FIFO, distributed-RAM storage with combinational read port.
// Pointers wrap naturally; count carries one extra bit so full is representable.
module uart_tx_buf_sync_fifo
  import uart_tx_buf_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// FIFO-buffered TX-only UART: ready/valid byte input, configurable frame,
// bit timing from a shared oversampled ck_en strobe, IOB-registered tx_pin.
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter  int DATA_BITS  = 8,
  parameter  int OVERSAMPLE = 16,
  parameter  int FIFO_DEPTH = 16,
  parameter  int PARITY_EN  = 0,
  parameter  int PARITY_ODD = 0,
  parameter  int STOP_BITS  = 1,
  localparam int CW         = clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ck_en,
  input  logic                 data_en,
  input  logic [DATA_BITS-1:0] data_tx,
  output logic                 data_rdy,
  output logic                 overflow,
  output logic [CW-1:0]        fifo_cnt,
  output logic                 busy,
  output logic                 tx_pin
);

  localparam int PW = (clog2(OVERSAMPLE) < 1) ? 1 : clog2(OVERSAMPLE);
  localparam int BW = (clog2(DATA_BITS) < 1) ? 1 : clog2(DATA_BITS);
  localparam logic PMODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic [PW-1:0]        phase;
  logic [BW-1:0]        bit_cnt;
  logic                 tx_loc;

  logic                 fifo_full, fifo_empty, pop, bit_end, last_stop;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_tx_buf_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (data_en),
    .din   (data_tx),
    .full  (fifo_full),
    .rd_en (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Ready comes from the registered count: a write racing a pop while full is lost.
  assign data_rdy  = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign bit_end   = ck_en && (phase == PW'(OVERSAMPLE - 1));
  assign last_stop = (state == S_STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
  assign pop       = !fifo_empty && ((state == S_IDLE) || last_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      par      <= 1'b0;
      phase    <= '0;
      bit_cnt  <= '0;
      tx_loc   <= 1'b1;
      tx_pin   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      tx_pin   <= tx_loc;
      overflow <= data_en && fifo_full;
      if (state != S_IDLE && ck_en)
        phase <= bit_end ? '0 : phase + PW'(1);
      case (state)
        S_IDLE: ;
        S_START:
          if (bit_end) begin
            state  <= S_DATA;
            tx_loc <= shreg[0];
          end
        S_DATA:
          if (bit_end) begin
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state  <= S_PARITY;
                tx_loc <= par;
              end else begin
                state  <= S_STOP;
                tx_loc <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg >> 1;
              tx_loc  <= shreg[1];
            end
          end
        S_PARITY:
          if (bit_end) begin
            state  <= S_STOP;
            tx_loc <= 1'b1;
          end
        S_STOP:
          if (bit_end) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        default: state <= S_IDLE;
      endcase
      // Load overrides the above, so a stop-end pop chains straight into START.
      if (pop) begin
        shreg   <= fifo_dout;
        par     <= (^fifo_dout) ^ PMODE;
        phase   <= '0;
        bit_cnt <= '0;
        tx_loc  <= 1'b0;
        state   <= S_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: three configurations, a ck_en-counting line receiver
// per instance feeding a scoreboard, plus timing sequences for frame corners.
module tb_uart_tx_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc  = 0;
  int   rcnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rcnt <= rcnt + 1;

  int nvec = 0;
  int nerr = 0;

  // A: defaults, ck_en every 4 clk
  logic       ck_a, en_a, rdy_a, ovf_a, busy_a, tx_a;
  logic [7:0] din_a;
  logic [4:0] cnt_a;
  // B: 7 data bits, odd parity, 2 stop, OVERSAMPLE=4, ck_en high
  logic       ck_b, en_b, rdy_b, ovf_b, busy_b, tx_b;
  logic [6:0] din_b;
  logic [4:0] cnt_b;
  // C: 8N1, OVERSAMPLE=4, ck_en driven by the test
  logic       ck_c, en_c, rdy_c, ovf_c, busy_c, tx_c;
  logic [7:0] din_c;
  logic [4:0] cnt_c;

  uart_tx_buf u_a (
    .clk(clk), .rst_n(rst_n), .ck_en(ck_a), .data_en(en_a), .data_tx(din_a),
    .data_rdy(rdy_a), .overflow(ovf_a), .fifo_cnt(cnt_a), .busy(busy_a), .tx_pin(tx_a));

  uart_tx_buf #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ck_en(ck_b), .data_en(en_b), .data_tx(din_b),
    .data_rdy(rdy_b), .overflow(ovf_b), .fifo_cnt(cnt_b), .busy(busy_b), .tx_pin(tx_b));

  uart_tx_buf #(.OVERSAMPLE(4)) u_c (
    .clk(clk), .rst_n(rst_n), .ck_en(ck_c), .data_en(en_c), .data_tx(din_c),
    .data_rdy(rdy_c), .overflow(ovf_c), .fifo_cnt(cnt_c), .busy(busy_c), .tx_pin(tx_c));

  logic cks_a, cks_b, cks_c;
  always @(posedge clk) begin
    cks_a <= ck_a;
    cks_b <= ck_b;
    cks_c <= ck_c;
  end

  initial begin
    ck_a = 1'b0;
    forever begin
      @(negedge clk);
      ck_a = (cyc % 4 == 0);
    end
  end

  logic [15:0] q_a[$], q_b[$], q_c[$];
  int          st_c[$];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic txs(input int s);
    case (s)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic cks(input int s);
    case (s)
      0:       return cks_a;
      1:       return cks_b;
      default: return cks_c;
    endcase
  endfunction

  function automatic logic [15:0] frm8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic frame_done(input int sel, input logic [15:0] got, input int t0);
    logic [15:0] e;
    if (sel == 2) st_c.push_back(t0);
    case (sel)
      0: if (q_a.size() == 0) chk("frame_a_unexpected", int'(got), -1);
         else begin e = q_a.pop_front(); chk("frame_a", int'(got), int'(e)); end
      1: if (q_b.size() == 0) chk("frame_b_unexpected", int'(got), -1);
         else begin e = q_b.pop_front(); chk("frame_b", int'(got), int'(e)); end
      default:
         if (q_c.size() == 0) chk("frame_c_unexpected", int'(got), -1);
         else begin e = q_c.pop_front(); chk("frame_c", int'(got), int'(e)); end
    endcase
  endtask

  // Line receiver: counts ck_en pulses like a real oversampling RX, so it
  // stays aligned when the test stalls ck_en mid-frame.
  task automatic mon(input int sel, input int half, input int os, input int nb);
    logic [15:0] got;
    int          r0, t0, need;
    logic        ok;
    forever begin
      @(negedge clk);
      if (!rst_n || txs(sel)) continue;
      r0 = rcnt; t0 = cyc; got = '0; ok = 1'b1;
      for (int i = 0; i < nb && ok; i++) begin
        need = (i == 0) ? half : os;
        while (need > 0 && ok) begin
          @(negedge clk);
          if (rcnt != r0) ok = 1'b0;
          else if (cks(sel)) need--;
        end
        got[i] = txs(sel);
      end
      if (ok) frame_done(sel, got, t0);
    end
  endtask

  initial mon(0, 8, 16, 10);
  initial mon(1, 2, 4, 11);
  initial mon(2, 2, 4, 10);

  task automatic wr(input int sel, input logic [8:0] d);
    case (sel)
      0:       begin en_a = 1'b1; din_a = d[7:0]; end
      1:       begin en_b = 1'b1; din_b = d[6:0]; end
      default: begin en_c = 1'b1; din_c = d[7:0]; end
    endcase
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    int n;
    n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, q_a.size() + q_b.size() + q_c.size(), 0);
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    int          sel;
    logic [8:0]  din;
    logic [15:0] frame;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   ed[$];
    int   exp5[8];
    int   n, t0;
    logic prev;

    // frame bit i = i-th bit on the line, start bit first
    tbl[0] = '{1, 9'h003, 16'h0706};
    tbl[1] = '{1, 9'h07F, 16'h06FE};
    tbl[2] = '{2, 9'h000, 16'h0200};
    tbl[3] = '{1, 9'h000, 16'h0700};
    tbl[4] = '{2, 9'h0FF, 16'h03FE};
    tbl[5] = '{1, 9'h055, 16'h07AA};
    tbl[6] = '{2, 9'h081, 16'h0302};
    tbl[7] = '{2, 9'h03C, 16'h0278};
    exp5   = '{0, 4, 8, 12, 16, 24, 28, 32};

    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    ck_b = 1'b1; ck_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_rdy_a", rdy_a, 1);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_tx_c", tx_c, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x55 on defaults: start latency, 64-clk bits, busy after stop
    q_a.push_back(16'h02AA);
    wr(0, 9'h055);
    chk("t1_cnt_after_wr", cnt_a, 1);
    chk("t1_busy_after_wr", busy_a, 1);
    n = 0;
    while (tx_a && n < 10) begin @(negedge clk); n++; end
    chk("t1_start_latency", n, 2);
    ed.delete();
    ed.push_back(cyc);
    prev = 1'b0;
    n = 0;
    while (ed.size() < 10 && n < 1000) begin
      @(negedge clk);
      n++;
      if (tx_a != prev) begin prev = tx_a; ed.push_back(cyc); end
    end
    chk("t1_edge_count", ed.size(), 10);
    if (ed.size() == 10) begin
      chk("t1_start_len_in_61_64", int'((ed[1] - ed[0] >= 61) && (ed[1] - ed[0] <= 64)), 1);
      for (int k = 2; k < 10; k++) chk("t1_bit_len", ed[k] - ed[k-1], 64);
      n = 0;
      while (busy_a && n < 200) begin @(negedge clk); n++; end
      // busy tracks the FSM, which runs one clk ahead of the IOB flop
      chk("t1_busy_fall", cyc - ed[9], 63);
      chk("t1_idle_high", tx_a, 1);
    end
    drain("t1_drain", 200);

    for (int i = 0; i < 8; i++) begin
      case (tbl[i].sel)
        1:       q_b.push_back(tbl[i].frame);
        default: q_c.push_back(tbl[i].frame);
      endcase
      wr(tbl[i].sel, tbl[i].din);
    end
    drain("vec_drain", 1000);

    // ck_en high, OVERSAMPLE=4: every bit exactly 4 clk
    q_c.push_back(16'h034A);
    wr(2, 9'h0A5);
    n = 0;
    while (tx_c && n < 10) begin @(negedge clk); n++; end
    t0 = cyc;
    ed.delete();
    ed.push_back(0);
    prev = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (tx_c != prev) begin prev = tx_c; ed.push_back(cyc - t0); end
    end
    chk("t5_edge_count", ed.size(), 8);
    if (ed.size() == 8)
      for (int k = 0; k < 8; k++) chk("t5_edge_time", ed[k], exp5[k]);
    drain("t5_drain", 200);

    // reset in the middle of data bit 3 (a 0 bit of 0xF0)
    wr(2, 9'h0F0);
    repeat (19) @(negedge clk);
    chk("t4_mid_bit3_low", tx_c, 0);
    chk("t4_busy_mid", busy_c, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_tx_high_in_reset", tx_c, 1);
    chk("t4_cnt_zero", cnt_c, 0);
    chk("t4_busy_zero", busy_c, 0);
    chk("t4_rdy_one", rdy_c, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    q_c.push_back(16'h0278);
    wr(2, 9'h03C);
    drain("t4_clean_drain", 200);

    // fill with the FSM stalled on ck_en, overflow, then write racing a pop
    ck_c = 1'b0;
    q_c.push_back(frm8(8'h11));
    wr(2, 9'h011);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      q_c.push_back(frm8(8'h20 + 8'(k)));
      wr(2, 9'(8'h20 + 8'(k)));
    end
    chk("t2_cnt_full", cnt_c, 16);
    chk("t2_rdy_low", rdy_c, 0);
    wr(2, 9'h099);
    chk("t2_overflow_pulse", ovf_c, 1);
    chk("t2_cnt_held", cnt_c, 16);
    @(negedge clk);
    chk("t2_overflow_clear", ovf_c, 0);
    ck_c = 1'b1;
    repeat (39) @(negedge clk);
    chk("t6_cnt_pre", cnt_c, 16);
    wr(2, 9'h0EE);
    chk("t6_cnt_after_pop", cnt_c, 15);
    chk("t6_overflow_pulse", ovf_c, 1);
    chk("t6_rdy_back", rdy_c, 1);
    st_c.delete();
    drain("t2_drain", 2000);
    chk("t2_frame_count", st_c.size(), 16);
    if (st_c.size() == 16) chk("t2_no_gap", st_c[15] - st_c[0], 600);
    chk("t2_idle_cnt", cnt_c, 0);
    chk("t2_idle_busy", busy_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
